// File: rtl/tetris_pixel_fetch.sv
// Board-cell fetcher for the VGA output stage: one RAM read per group,
// expanded to a 16-pixel packed word ready before the group's load slot.
module tetris_pixel_fetch #(
    parameter int         BOARD_W     = 10,
    parameter int         BOARD_H     = 20,
    parameter int         H_ORG_GRP   = 8,
    parameter int         V_ORG       = 80,
    parameter int         CELL_SHIFT  = 4,
    parameter int         RAM_LAT     = 1,
    parameter int         FETCH_PHASE = 4,
    parameter logic [2:0] BG_COLOR    = 3'b000,
    parameter int         GRID_EN     = 1,
    parameter logic [2:0] GRID_COLOR  = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ram_rd,
    output logic [7:0]  ram_addr,
    input  logic [2:0]  ram_data,
    output logic [47:0] pixels,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [10:0] H_LAST      = 11'd1600;
    localparam logic [9:0]  V_LAST      = 10'd521;
    localparam int          BOARD_LINES = BOARD_H << CELL_SHIFT;
    localparam int          LW          = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LW-1:0] LAT_END   = LW'(RAM_LAT - 1);

    if (FETCH_PHASE + RAM_LAT + 3 >= 63) begin : g_bad_phase
        $error("fetch does not finish before the group load slot");
    end
    if (RAM_LAT < 1) begin : g_bad_lat
        $error("RAM_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, BUILD} state_t;

    state_t          state_q, state_d;
    logic [10:0]     h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic            ram_rd_q, ram_rd_d;
    logic [7:0]      addr_q, addr_d;
    logic            hit_q, hit_d;
    logic            edge_q, edge_d;
    logic [2:0]      color_q, color_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [47:0]     pixels_q, pixels_d;
    logic            vblank_q, vblank_d;
    logic            fs_q, fs_d;

    logic [5:0]      gx, col;
    logic [9:0]      dv;
    logic            h_on, v_on, hit, cell_edge;
    logic [7:0]      row8, addr_calc;
    logic [47:0]     word;

    assign ram_rd      = ram_rd_q;
    assign ram_addr    = addr_q;
    assign pixels      = pixels_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

    // Counters and geometry of the group being prepared (one ahead of display)
    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        gx        = {1'b0, h_q[10:6]} + 6'd1;
        col       = gx - 6'(H_ORG_GRP);
        dv        = v_q - 10'(V_ORG);
        h_on      = (gx >= 6'(H_ORG_GRP)) && (col < 6'(BOARD_W));
        v_on      = (v_q >= 10'(V_ORG)) && (dv < 10'(BOARD_LINES));
        hit       = h_on && v_on;
        row8      = 8'(dv >> CELL_SHIFT);
        addr_calc = row8 * 8'(BOARD_W) + 8'(col);
        cell_edge = (dv[CELL_SHIFT-1:0] == '0);
        vblank_d  = !v_on;
        fs_d      = (h_q == '0) && (v_q == '0);
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < 16; i++) begin
            if (GRID_EN != 0 && hit_q && color_q != 3'b000 &&
                (i == 0 || edge_q))
                word[i*3 +: 3] = GRID_COLOR;
            else
                word[i*3 +: 3] = color_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        ram_rd_d = 1'b0;
        addr_d   = addr_q;
        hit_d    = hit_q;
        edge_d   = edge_q;
        color_d  = color_q;
        lat_d    = lat_q;
        pixels_d = pixels_q;
        unique case (state_q)
            IDLE: begin
                if (h_q[5:0] == 6'(FETCH_PHASE)) begin
                    state_d = REQ;
                    hit_d   = hit;
                    edge_d  = cell_edge;
                    if (hit) begin
                        ram_rd_d = 1'b1;
                        addr_d   = addr_calc;
                    end
                end
            end
            REQ: begin
                lat_d = '0;
                if (hit_q) begin
                    state_d = WAIT;
                end else begin
                    color_d = BG_COLOR;
                    state_d = BUILD;
                end
            end
            WAIT: begin
                if (lat_q == LAT_END) begin
                    color_d = ram_data;
                    state_d = BUILD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            BUILD: begin
                pixels_d = word;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            h_q      <= '0;
            v_q      <= '0;
            ram_rd_q <= 1'b0;
            addr_q   <= '0;
            hit_q    <= 1'b0;
            edge_q   <= 1'b0;
            color_q  <= '0;
            lat_q    <= '0;
            pixels_q <= '0;
            vblank_q <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            ram_rd_q <= ram_rd_d;
            addr_q   <= addr_d;
            hit_q    <= hit_d;
            edge_q   <= edge_d;
            color_q  <= color_d;
            lat_q    <= lat_d;
            pixels_q <= pixels_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
        end
    end

endmodule

// File: tb/tb_tetris_pixel_fetch.sv
// Scoreboard bench: two fetchers (grid/lat1/bg0 and plain/lat3/bg3) against
// a frame-position reference model over a small board.
module tb_tetris_pixel_fetch;

    localparam int TB_BW   = 10;
    localparam int TB_BH   = 4;
    localparam int TB_HORG = 8;
    localparam int TB_VORG = 2;
    localparam int TB_CS   = 2;
    localparam int TB_CL   = 4;
    localparam int H_PER   = 1601;
    localparam int V_PER   = 522;

    typedef struct { int due; logic [7:0] addr; } rd_exp_t;
    typedef struct { int due; logic [47:0] word; } px_exp_t;
    typedef struct { bit v; logic [2:0] d; } pipe_t;

    logic       clk;
    logic       rst;
    int         n;
    int         total;
    int         bad;
    logic [2:0] board [0:255];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Cycle position since the last reset edge; h=n%1601, v=n/1601
    initial begin
        n = 0;
        forever begin
            @(posedge clk);
            if (rst) n = 0;
            else n = n + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    function automatic int cell_index(int v, int gx);
        int col;
        int dv;
        col = gx - TB_HORG;
        dv  = v - TB_VORG;
        if (col < 0 || col >= TB_BW || dv < 0 || dv >= TB_BH * TB_CL)
            return -1;
        return (dv / TB_CL) * TB_BW + col;
    endfunction

    function automatic logic [47:0] exp_word(int v, int gx, bit grid,
                                             logic [2:0] bg);
        logic [47:0] w;
        logic [2:0]  c;
        int          idx;
        bit          top;
        w   = '0;
        idx = cell_index(v, gx);
        top = ((v - TB_VORG) % TB_CL) == 0;
        for (int i = 0; i < 16; i++) begin
            if (idx < 0) begin
                w[i*3 +: 3] = bg;
            end else begin
                c = board[idx];
                if (grid && c != 3'b000 && (i == 0 || top))
                    w[i*3 +: 3] = 3'b111;
                else
                    w[i*3 +: 3] = c;
            end
        end
        return w;
    endfunction

    task automatic fill_board();
        for (int i = 0; i < 256; i++)
            board[i] = 3'($urandom_range(0, 7));
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int         LAT = (k == 0) ? 1 : 3;
        localparam int         GEN = (k == 0) ? 1 : 0;
        localparam logic [2:0] BG  = (k == 0) ? 3'b000 : 3'b011;

        logic        ram_rd;
        logic [7:0]  ram_addr;
        logic [2:0]  ram_data;
        logic [47:0] pixels;
        logic        vblank;
        logic        frame_start;

        rd_exp_t addr_q [$];
        px_exp_t pix_q  [$];
        pipe_t   pipe   [$];

        tetris_pixel_fetch #(
            .BOARD_W(TB_BW), .BOARD_H(TB_BH), .H_ORG_GRP(TB_HORG),
            .V_ORG(TB_VORG), .CELL_SHIFT(TB_CS), .RAM_LAT(LAT),
            .FETCH_PHASE(4), .BG_COLOR(BG), .GRID_EN(GEN),
            .GRID_COLOR(3'b111)
        ) dut (
            .clk(clk), .rst(rst), .ram_rd(ram_rd), .ram_addr(ram_addr),
            .ram_data(ram_data), .pixels(pixels), .vblank(vblank),
            .frame_start(frame_start)
        );

        // Board RAM: data valid exactly LAT cycles after the strobe, noise otherwise
        initial begin : ram_model
            pipe_t e;
            ram_data = 3'b000;
            forever begin
                @(posedge clk);
                #1;
                e.v = ram_rd;
                e.d = board[ram_addr];
                pipe.push_back(e);
                ram_data = 3'($urandom_range(0, 7));
                if (pipe.size() > LAT) begin
                    e = pipe.pop_front();
                    if (e.v) ram_data = e.d;
                end
            end
        end

        initial begin : ref_model
            int      h;
            int      v;
            int      gx;
            int      idx;
            rd_exp_t r;
            px_exp_t p;
            forever begin
                @(posedge clk);
                #2;
                if (n == 0) begin
                    addr_q.delete();
                    pix_q.delete();
                end else begin
                    h = n % H_PER;
                    v = (n / H_PER) % V_PER;
                    if (h % 64 == 4 && h < 1600) begin
                        gx  = h / 64 + 1;
                        idx = cell_index(v, gx);
                        if (idx >= 0) begin
                            r.due  = n + 1;
                            r.addr = 8'(idx);
                            addr_q.push_back(r);
                        end
                        p.word = exp_word(v, gx, GEN != 0, BG);
                        p.due  = n + 28;
                        pix_q.push_back(p);
                        p.due  = n + 59;
                        pix_q.push_back(p);
                        p.due  = n + 60;
                        pix_q.push_back(p);
                    end
                end
            end
        end

        initial begin : monitor
            int      vp;
            bit      vb;
            rd_exp_t r;
            px_exp_t p;
            @(posedge clk);
            forever begin
                @(negedge clk);
                if (n == 0) begin
                    check($sformatf("i%0d rst pixels", k), 64'(pixels), 0);
                    check($sformatf("i%0d rst ram_rd", k), 64'(ram_rd), 0);
                    check($sformatf("i%0d rst ram_addr", k), 64'(ram_addr), 0);
                    check($sformatf("i%0d rst vblank", k), 64'(vblank), 1);
                    check($sformatf("i%0d rst frame_start", k),
                          64'(frame_start), 0);
                end else begin
                    vp = ((n - 1) / H_PER) % V_PER;
                    vb = !(vp >= TB_VORG && vp < TB_VORG + TB_BH * TB_CL);
                    check($sformatf("i%0d vblank", k), 64'(vblank), 64'(vb));
                    check($sformatf("i%0d frame_start", k), 64'(frame_start),
                          64'(((n - 1) % (H_PER * V_PER)) == 0));
                end
                if (addr_q.size() > 0 && addr_q[0].due <= n) begin
                    r = addr_q.pop_front();
                    check($sformatf("i%0d ram_rd due", k), 64'(ram_rd), 1);
                    if (ram_rd)
                        check($sformatf("i%0d ram_addr", k), 64'(ram_addr),
                              64'(r.addr));
                end else if (ram_rd) begin
                    check($sformatf("i%0d ram_rd spurious", k), 64'(ram_rd), 0);
                end
                if (pix_q.size() > 0 && pix_q[0].due == n) begin
                    p = pix_q.pop_front();
                    check($sformatf("i%0d pixels h=%0d", k, n % H_PER),
                          64'(pixels), 64'(p.word));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        fill_board();
        board[0] = 3'b001;
        board[TB_BW * TB_BH - 1] = 3'b010;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset mid-fetch: the ram_rd cycle of group 10 on a board line
        do begin
            @(posedge clk);
            #1;
        end while (n != 5 * H_PER + 10 * 64 + 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill_board();
        board[0] = 3'b000;
        rst = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (n < 21 * H_PER + 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tetris_pixel_fetch.md
Name: tetris_pixel_fetch

Overview:
- Upstream feeder for the 50 MHz VGA output stage. It renders the Tetris playfield from a board RAM into the 48-bit packed pixel word the output stage loads once per 64-clock group.
- Runs its own horizontal/vertical counters in lockstep with the output stage; both come out of the same reset. For every group it reads one board cell and expands it to 16  3-bit pixels.
- Also tells game logic when the board RAM may be written without tearing.

Parameters:
- BOARD_W, 10, playfield width in cells (one cell = one 64-clock group).
- BOARD_H, 20, playfield height in cells.
- H_ORG_GRP, 8, group index of the leftmost board column (h_cnt[10:6]).
- V_ORG, 80, first line of the board.
- CELL_SHIFT, 4, log2 of lines per cell (16).
- RAM_LAT, 1, board RAM read latency in clocks.
- FETCH_PHASE, 4, value of h_cnt[5:0] at which a fetch starts.
- BG_COLOR, 3'b000, colour used off-board.
- GRID_EN, 1, enables cell outlines.
- GRID_COLOR, 3'b111, outline colour.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- ram_rd  out  1  board RAM read strobe, one cycle wide.
- ram_addr  out  8  cell address = row*BOARD_W + col.
- ram_data  in  3  cell colour, valid RAM_LAT cycles after ram_rd.
- pixels  out  48  packed word for the next group; [2:0] is the first pixel shown.
- vblank  out  1  high while v_cnt is outside the board rows; game logic writes RAM only then.
- frame_start  out  1  one-cycle pulse when h_cnt==0 and v_cnt==0.

Behaviour:
- Reset values: pixels=0, ram_rd=0, ram_addr=0, vblank=1, frame_start=0, h_cnt=0, v_cnt=0, FSM=IDLE.
- Reset is synchronous, so asserting it mid-fetch abandons the fetch; no partial pixels update occurs.
- Counters:
  - h_cnt is 11 bits and counts 0..1600 inclusive (period 1601), then wraps to 0.
  - On that wrap, v_cnt (10 bits) increments over 0..521 (period 522) and wraps to 0.
  - These periods match the output stage exactly.
- Target group: gx = h_cnt[10:6]+1. The word built during group g is loaded by the output stage at h_cnt[5:0]==63 and displayed in group g+1.
- Board hit: col = gx-H_ORG_GRP, dv = v_cnt-V_ORG, row = dv>>CELL_SHIFT. It is a hit when 0<=col<BOARD_W and 0<=dv<(BOARD_H<<CELL_SHIFT). Use unsigned compare after checking gx>=H_ORG_GRP and v_cnt>=V_ORG.
- FSM states:
  - IDLE: go to REQ when h_cnt[5:0]==FETCH_PHASE. On a board hit, register ram_addr and set ram_rd=1 for the next cycle only. On a miss, no read occurs.
  - REQ: ram_rd high one cycle; go to WAIT. A miss skips straight to BUILD with colour=BG_COLOR.
  - WAIT: count RAM_LAT-1 further cycles, then capture ram_data and go to BUILD.
  - BUILD: form the word and register it into pixels; return to IDLE.
- Word formation:
  - Base word: all 16 slots = cell colour.
  - If GRID_EN, the cell is a hit and its colour is nonzero, then slot 0 = GRID_COLOR. If in addition dv[CELL_SHIFT-1:0]==0, all slots = GRID_COLOR.
  - Colour 0 cells render as 3'b000 with no outline.
- Timing guarantees:
  - pixels changes only in BUILD and is stable from then through h_cnt[5:0]==63.
  - Required: FETCH_PHASE+RAM_LAT+3 < 63 (checked by an elaboration-time assertion).
- Group 25 lasts only one clock (h_cnt=1600), so no fetch starts in it; pixels holds its previous value. That value is BG_COLOR, because group 24 targets group 25, which is off-board.
- Exactly one ram_rd per hit group per line; BOARD_W reads on every board line and zero on other lines.
- vblank and frame_start are registered from the counters, with one-cycle latency.
- Row/column arithmetic: row*BOARD_W is a constant multiply, 8-bit result. Compare widths must be wide enough that a negative dv or col never aliases to a hit.

Test Plan:
- Reset, then run one frame with all cells = 0 -> pixels==0 throughout; frame_start pulses exactly once per 835,722 clocks; vblank low only for v_cnt 80..399.
- GRID_EN=0, cell(0,0)=3'b101, v_cnt=85 -> ram_addr=0 with ram_rd one cycle at h_cnt==453; pixels==48'hB6DB6DB6DB6D at h_cnt 511; off-board groups give 0.
- GRID_EN=1, cell(0,0)=3'b001 -> line 80: pixels==48'hFFFFFFFFFFFF at h_cnt 511; line 81: pixels==48'h24924924924F.
- cell(19,9)=3'b010 at line 399 -> ram_addr==199, ram_rd during group 16; line 400 issues no reads and vblank rises.
- RAM_LAT=3 with ram_data changing every cycle -> capture takes the value exactly 3 cycles after ram_rd, and pixels is stable through h_cnt[5:0]==63.
- Assert rst at h_cnt[5:0]==FETCH_PHASE+1 for one cycle -> all outputs at reset values the next cycle; after release, first on-board word is correct and counters stay aligned with a freshly reset output stage.
